// File: rtl/starter_evolution_ctrl_if.sv
// Bus between the starter/evolution controller and its environment: player
// inputs, map/battle status, and the registered sprite-selection outputs.
interface starter_evolution_ctrl_if;
   logic       start;
   logic       btn_left;
   logic       btn_right;
   logic       btn_confirm;
   logic [1:0] map_level;
   logic       battle_active;
   logic [1:0] cursor;
   logic [3:0] chosenPokemon;
   logic [4:0] pkmnID;
   logic       selection_done;
   logic       evolving;

   modport master (
      output start, btn_left, btn_right, btn_confirm, map_level, battle_active,
      input  cursor, chosenPokemon, pkmnID, selection_done, evolving
   );

   modport slave (
      input  start, btn_left, btn_right, btn_confirm, map_level, battle_active,
      output cursor, chosenPokemon, pkmnID, selection_done, evolving
   );
endinterface

// File: rtl/starter_evolution_ctrl.sv
// Starter selection and evolution sequencer driving the back-sprite ROM.
// Optional macro STARTER_EVOLVE_FLASH_EN: old/new sprite flashing during evolution.
module starter_evolution_ctrl #(
   parameter int unsigned EVOLVE_CYCLES = 120,
   parameter int unsigned FLASH_PERIOD  = 8
) (
   input  logic                     Clk,
   input  logic                     Reset,
   starter_evolution_ctrl_if.slave  bus
);

   localparam int unsigned TMR_W = (EVOLVE_CYCLES > 2) ? $clog2(EVOLVE_CYCLES) : 1;

   if (EVOLVE_CYCLES < 2 || FLASH_PERIOD < 1) begin : g_param_chk
      $error("starter_evolution_ctrl: EVOLVE_CYCLES must be >= 2 and FLASH_PERIOD >= 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BROWSE = 2'd1,
      ST_LOCKED = 2'd2,
      ST_EVOLVE = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [1:0]       cursor_q, cursor_d;
   logic [1:0]       family_q, family_d;
   logic [1:0]       stage_q, stage_d;
   logic [3:0]       chosen_q, chosen_d;
   logic [4:0]       pkmn_q, pkmn_d;
   logic             sel_done_q, sel_done_d;
   logic             evolving_q, evolving_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             start_prev_q, left_prev_q, right_prev_q, confirm_prev_q;

`ifdef STARTER_EVOLVE_FLASH_EN
   localparam int unsigned FL_W = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
   logic [FL_W-1:0] flash_cnt_q, flash_cnt_d;
   logic            flash_phase_q, flash_phase_d;
`endif

   logic       start_rise, left_rise, right_rise, confirm_rise;
   logic [1:0] target;
   logic [3:0] cur_code, next_code;

   assign start_rise   = bus.start       & ~start_prev_q;
   assign left_rise    = bus.btn_left    & ~left_prev_q;
   assign right_rise   = bus.btn_right   & ~right_prev_q;
   assign confirm_rise = bus.btn_confirm & ~confirm_prev_q;

   // Map levels beyond the last evolution stage clamp to stage 2.
   assign target    = (bus.map_level > 2'd2) ? 2'd2 : bus.map_level;
   assign cur_code  = 4'(stage_q) * 4'd3 + 4'(family_q);
   assign next_code = cur_code + 4'd3;

   // Next-state and output logic
   always_comb begin
      state_d    = state_q;
      cursor_d   = cursor_q;
      family_d   = family_q;
      stage_d    = stage_q;
      chosen_d   = chosen_q;
      pkmn_d     = pkmn_q;
      sel_done_d = sel_done_q;
      evolving_d = evolving_q;
      timer_d    = timer_q;
`ifdef STARTER_EVOLVE_FLASH_EN
      flash_cnt_d   = flash_cnt_q;
      flash_phase_d = flash_phase_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (start_rise) begin
               state_d = ST_BROWSE;
               pkmn_d  = 5'd3 + 5'(cursor_q);
            end
         end
         ST_BROWSE: begin
            if (confirm_rise) begin
               family_d   = cursor_q;
               stage_d    = 2'd0;
               chosen_d   = 4'(cursor_q);
               pkmn_d     = 5'd3 + 5'(cursor_q);
               sel_done_d = 1'b1;
               state_d    = ST_LOCKED;
            end else begin
               if (right_rise && !left_rise) begin
                  cursor_d = (cursor_q == 2'd2) ? 2'd0 : cursor_q + 2'd1;
               end else if (left_rise && !right_rise) begin
                  cursor_d = (cursor_q == 2'd0) ? 2'd2 : cursor_q - 2'd1;
               end
               pkmn_d = 5'd3 + 5'(cursor_d);
            end
         end
         ST_LOCKED: begin
            if (target > stage_q && !bus.battle_active) begin
               state_d    = ST_EVOLVE;
               evolving_d = 1'b1;
               timer_d    = '0;
`ifdef STARTER_EVOLVE_FLASH_EN
               flash_cnt_d   = '0;
               flash_phase_d = 1'b0;
`endif
            end
         end
         ST_EVOLVE: begin
            if (timer_q == TMR_W'(EVOLVE_CYCLES - 1)) begin
               stage_d    = stage_q + 2'd1;
               chosen_d   = next_code;
               pkmn_d     = 5'd3 + 5'(next_code);
               evolving_d = 1'b0;
               state_d    = ST_LOCKED;
            end else begin
               timer_d = timer_q + TMR_W'(1);
`ifdef STARTER_EVOLVE_FLASH_EN
               // Phase 0 shows the old sprite, phase 1 the new one.
               if (flash_cnt_q == FL_W'(FLASH_PERIOD - 1)) begin
                  flash_cnt_d   = '0;
                  flash_phase_d = ~flash_phase_q;
                  pkmn_d        = flash_phase_q ? 5'd3 + 5'(cur_code)
                                                : 5'd3 + 5'(next_code);
               end else begin
                  flash_cnt_d = flash_cnt_q + FL_W'(1);
               end
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset aborts any evolution in progress.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q        <= ST_IDLE;
         cursor_q       <= 2'd0;
         family_q       <= 2'd0;
         stage_q        <= 2'd0;
         chosen_q       <= 4'b1111;
         pkmn_q         <= 5'b11111;
         sel_done_q     <= 1'b0;
         evolving_q     <= 1'b0;
         timer_q        <= '0;
         start_prev_q   <= 1'b0;
         left_prev_q    <= 1'b0;
         right_prev_q   <= 1'b0;
         confirm_prev_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cursor_q       <= cursor_d;
         family_q       <= family_d;
         stage_q        <= stage_d;
         chosen_q       <= chosen_d;
         pkmn_q         <= pkmn_d;
         sel_done_q     <= sel_done_d;
         evolving_q     <= evolving_d;
         timer_q        <= timer_d;
         start_prev_q   <= bus.start;
         left_prev_q    <= bus.btn_left;
         right_prev_q   <= bus.btn_right;
         confirm_prev_q <= bus.btn_confirm;
      end
   end

`ifdef STARTER_EVOLVE_FLASH_EN
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         flash_cnt_q   <= '0;
         flash_phase_q <= 1'b0;
      end else begin
         flash_cnt_q   <= flash_cnt_d;
         flash_phase_q <= flash_phase_d;
      end
   end
`endif

   assign bus.cursor         = cursor_q;
   assign bus.chosenPokemon  = chosen_q;
   assign bus.pkmnID         = pkmn_q;
   assign bus.selection_done = sel_done_q;
   assign bus.evolving       = evolving_q;

endmodule

// File: tb/tb_starter_evolution_ctrl.sv
// Directed self-checking bench for starter_evolution_ctrl.
module tb_starter_evolution_ctrl;

   localparam int unsigned N = 120;
`ifdef STARTER_EVOLVE_FLASH_EN
   localparam bit FLASH = 1'b1;
`else
   localparam bit FLASH = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   starter_evolution_ctrl_if bus ();

   starter_evolution_ctrl #(.EVOLVE_CYCLES(N), .FLASH_PERIOD(8)) dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int cur, input int chosen, input int id,
                          input int sel, input int evo);
      chk({tag, ".cursor"},   32'(bus.cursor),         32'(cur));
      chk({tag, ".chosen"},   32'(bus.chosenPokemon),  32'(chosen));
      chk({tag, ".pkmnID"},   32'(bus.pkmnID),         32'(id));
      chk({tag, ".sel_done"}, 32'(bus.selection_done), 32'(sel));
      chk({tag, ".evolving"}, 32'(bus.evolving),       32'(evo));
   endtask

   task automatic press(input bit s, input bit l, input bit r, input bit c);
      bus.start = s; bus.btn_left = l; bus.btn_right = r; bus.btn_confirm = c;
      tick(1);
      bus.start = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_confirm = 1'b0;
      tick(1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.start = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_confirm = 1'b0;
      bus.map_level = 2'd0; bus.battle_active = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   initial begin
      // Session A: browsing, wrap-around, simultaneous presses, confirm
      do_reset();
      chk_out("reset", 0, 15, 31, 0, 0);
      press(1, 0, 0, 0);
      chk_out("browse_entry", 0, 15, 3, 0, 0);
      press(0, 0, 1, 0);
      press(0, 0, 1, 0);
      press(0, 1, 0, 0);
      chk_out("nav_rrl", 1, 15, 4, 0, 0);
      press(0, 1, 0, 0);
      chk("left_to_0", 32'(bus.cursor), 32'd0);
      press(0, 1, 0, 0);
      chk_out("wrap_left", 2, 15, 5, 0, 0);
      press(0, 1, 1, 0);
      chk_out("left_right_same", 2, 15, 5, 0, 0);
      bus.btn_right = 1'b1;
      tick(3);
      bus.btn_right = 1'b0;
      tick(1);
      chk_out("held_right_wrap", 0, 15, 3, 0, 0);
      press(0, 1, 0, 0);
      press(0, 0, 1, 1);
      chk_out("confirm_wins", 2, 2, 5, 1, 0);
      press(0, 0, 1, 0);
      chk_out("locked_ignores_btn", 2, 2, 5, 1, 0);
      tick(5);
      chk("level0_no_evolve", 32'(bus.evolving), 32'd0);

      // Session B: Charmander, evolution blocked by battle, battle mid-sequence
      do_reset();
      press(1, 0, 0, 0);
      press(0, 0, 1, 0);
      press(0, 0, 0, 1);
      chk_out("charmander", 1, 1, 4, 1, 0);
      bus.map_level = 2'd1;
      bus.battle_active = 1'b1;
      tick(50);
      chk_out("battle_blocks", 1, 1, 4, 1, 0);
      bus.battle_active = 1'b0;
      tick(1);
      chk("evolve_entry", 32'(bus.evolving), 32'd1);
      tick(10);
      bus.battle_active = 1'b1;
      tick(N - 11);
      chk("evolve_last_cycle", 32'(bus.evolving), 32'd1);
      chk("evolve_chosen_hold", 32'(bus.chosenPokemon), 32'd1);
      if (!FLASH) chk("evolve_id_hold", 32'(bus.pkmnID), 32'd4);
      tick(1);
      chk_out("charmeleon", 1, 4, 7, 1, 0);
      bus.map_level = 2'd2;
      tick(5);
      chk("battle_blocks_2", 32'(bus.evolving), 32'd0);
      bus.map_level = 2'd0;
      bus.battle_active = 1'b0;
      tick(5);
      chk_out("no_de_evolve", 1, 4, 7, 1, 0);

      // Session C: Bulbasaur, level jump 0 -> 3 gives two sequences
      do_reset();
      press(1, 0, 0, 0);
      press(0, 0, 0, 1);
      chk_out("bulbasaur", 0, 0, 3, 1, 0);
      bus.map_level = 2'd3;
      tick(1);
      chk("jump_evolve1", 32'(bus.evolving), 32'd1);
      tick(N - 1);
      chk("jump_evolve1_end", 32'(bus.evolving), 32'd1);
      tick(1);
      chk_out("ivysaur", 0, 3, 6, 1, 0);
      tick(1);
      chk_out("jump_evolve2", 0, 3, 6, 1, 1);
      tick(N - 1);
      chk("jump_evolve2_end", 32'(bus.evolving), 32'd1);
      tick(1);
      chk_out("venusaur", 0, 6, 9, 1, 0);
      bus.map_level = 2'd0;
      tick(5);
      chk_out("venusaur_lvl0", 0, 6, 9, 1, 0);
      bus.map_level = 2'd3;
      tick(5);
      chk_out("stage_saturates", 0, 6, 9, 1, 0);

      // Session D: asynchronous reset at cycle 60 of an evolution
      do_reset();
      press(1, 0, 0, 0);
      press(0, 0, 0, 1);
      bus.map_level = 2'd1;
      tick(1);
      chk_out("abort_entry", 0, 0, 3, 1, 1);
      tick(7);
      chk("flash_k7", 32'(bus.pkmnID), 32'd3);
      tick(1);
      chk("flash_k8", 32'(bus.pkmnID), FLASH ? 32'd6 : 32'd3);
      tick(52);
      chk_out("abort_k60", 0, 0, FLASH ? 6 : 3, 1, 1);
      rst = 1'b1;
      #1;
      chk_out("async_reset", 0, 15, 31, 0, 0);
      #1;
      rst = 1'b0;
      tick(N + 5);
      chk_out("no_commit_after_abort", 0, 15, 31, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/starter_evolution_ctrl.md
Name: starter_evolution_ctrl

Overview:
- Sequences the player's Pokémon choice: starter browse/confirm, then evolution stages as the map level advances.
- Produces the 4-bit chosenPokemon code and the 5-bit back-sprite pkmnID consumed by the sprite ROM/renderer.
- Defers evolution while a battle is active. Runs an evolution animation window before committing the new stage.

Parameters:
- EVOLVE_CYCLES, 120, length of the evolution sequence in Clk cycles (≥2).
- FLASH_PERIOD, 8, cycles per sprite toggle during evolution (used only with the optional feature).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  level; a rising edge leaves IDLE.
- btn_left  in  1  level; a rising edge moves the cursor left.
- btn_right  in  1  level; a rising edge moves the cursor right.
- btn_confirm  in  1  level; a rising edge locks the starter.
- map_level  in  2  current map, 0..3; values above 2 are treated as 2.
- battle_active  in  1  high during a battle; blocks evolution start.
- cursor  out  2  browse cursor: 0 = grass, 1 = fire, 2 = water.
- chosenPokemon  out  4  stage*3 + family (0..8); 4'b1111 = none.
- pkmnID  out  5  back-sprite ID; 5'b11111 = none.
- selection_done  out  1  high once a starter is locked.
- evolving  out  1  high in the EVOLVE state.

Behaviour:
- Clocking and reset:
  - One clock domain. Reset is asynchronous and active-high; Clk and Reset are the port names.
  - All outputs are registered.
  - Reset values: state = IDLE, cursor = 0, chosenPokemon = 4'b1111, pkmnID = 5'b11111, selection_done = 0, evolving = 0, family = 0, stage = 0, edge registers = 0, timers = 0.
  - Reset asserted mid-EVOLVE aborts the sequence immediately; nothing is committed.
- Edge detection:
  - Each button and start is registered once (prev). A rising edge is in = 1 and prev = 0.
  - Outputs change on the Clk edge following the cycle the rising edge was detected (1-cycle latency).
- Sprite mapping: pkmnID = 5'd3 + code, where code = stage*3 + family.
  - Examples: Bulbasaur 3, Charmeleon 7, Blastoise 11.
- State machine:
  - IDLE: outputs hold their reset values. A start rising edge goes to BROWSE.
  - BROWSE:
    - pkmnID previews 3 + cursor; chosenPokemon = 4'b1111.
    - right: cursor 0→1→2→0. left: cursor 0→2→1→0 (wraps both ways).
    - left and right rising in the same cycle: ignored.
    - confirm rising in the same cycle as left/right: confirm wins, and the cursor does not move.
    - confirm: family = cursor, stage = 0, chosenPokemon = family, pkmnID = 3 + family, selection_done = 1, go to LOCKED.
  - LOCKED:
    - target = min(map_level, 2).
    - If target > stage and battle_active = 0: go to EVOLVE, evolving = 1, timer = 0.
    - If battle_active = 1: wait, with no timeout.
    - Buttons are ignored.
  - EVOLVE:
    - Timer counts 0..EVOLVE_CYCLES-1.
    - At terminal count: stage += 1, chosenPokemon and pkmnID update to the new stage, evolving = 0, go to LOCKED.
    - Exactly one stage per sequence. A jump from 0 to 2 yields two back-to-back sequences, with 1 cycle in LOCKED between them.
    - battle_active rising during EVOLVE does not abort the sequence.
- Boundary rules:
  - map_level decreasing never de-evolves.
  - stage saturates at 2; in LOCKED with stage = 2, no further EVOLVE entry.
  - chosenPokemon never exceeds 8 except the 4'b1111 sentinel.

Optional Feature:
- Macro: STARTER_EVOLVE_FLASH_EN.
- Defined:
  - During EVOLVE, pkmnID toggles between the old and new stage sprite every FLASH_PERIOD cycles, starting with old.
  - A free-running flash counter resets on EVOLVE entry.
  - At exit, pkmnID equals the new sprite.
- Undefined:
  - pkmnID holds the old sprite for all of EVOLVE and changes only at commit.
  - No flash counter is synthesized.
- chosenPokemon behaves identically in both builds.

Test Plan:
- Reset, then start edge, then 2× right, 1× left → cursor = 1, pkmnID = 4, chosenPokemon = 4'b1111, selection_done = 0.
- BROWSE at cursor = 0, then left → cursor = 2, pkmnID = 5. Left and right in the same cycle → cursor unchanged.
- Confirm at cursor = 2 with map_level = 0 → chosenPokemon = 2, pkmnID = 5, selection_done = 1. A following right press has no effect.
- Locked Charmander (1), map_level = 1 while battle_active = 1 for 50 cycles → evolving stays 0. Drop battle_active → evolving = 1 for exactly EVOLVE_CYCLES cycles, then chosenPokemon = 4, pkmnID = 7.
- Locked Bulbasaur, map_level jumps from 0 to 3 → two evolutions → chosenPokemon = 6, pkmnID = 9. Then map_level = 0 → values unchanged.
- Reset pulsed at cycle 60 of EVOLVE → all outputs return to reset values on assertion, with no clock needed. With STARTER_EVOLVE_FLASH_EN defined, pkmnID alternates old/new every 8 cycles before the abort.
